// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared definitions for the fetch stage and its neighbours:
//   - default address / instruction widths
//   - 4-bit opcode constants (inst[15:12])
//   - fetch FSM state encodings
package fetch_stage_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INST_W  = 16;
  localparam int DEF_PC_STEP = 2;

  localparam logic [3:0] OPC_RTYPE = 4'h0;
  localparam logic [3:0] OPC_ANDI  = 4'h1;
  localparam logic [3:0] OPC_ORI   = 4'h2;
  localparam logic [3:0] OPC_BGT   = 4'h4;
  localparam logic [3:0] OPC_BLT   = 4'h5;
  localparam logic [3:0] OPC_BEQ   = 4'h6;
  localparam logic [3:0] OPC_LBU   = 4'hA;
  localparam logic [3:0] OPC_SB    = 4'hB;
  localparam logic [3:0] OPC_LW    = 4'hC;
  localparam logic [3:0] OPC_SW    = 4'hD;
  localparam logic [3:0] OPC_HALT  = 4'hF;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg
//   Generic pipeline stage register with load, hold and flush.
//   flush clears only the valid bit; the payload is held, since a
//   bubble's payload is never looked at downstream.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   asynchronous active-low reset
//     load   in   capture d and mark valid
//     flush  in   mark invalid (has priority over load)
//     d      in   payload [W-1:0]
//     q      out  registered payload
//     valid  out  register holds a real entry
module ifid_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch: owns the PC, presents it to a combinational
//   instruction memory and registers the returned instruction into IF/ID.
//   Handles sequential increment, branch redirect, stall hold and
//   HALT detection (RUN/HALTED FSM).
//   Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
//   Ports:
//     clk            in   clock, rising edge
//     rst            in   asynchronous active-low reset
//     stall          in   hold PC and IF/ID
//     branch_taken   in   redirect request (wins over stall)
//     branch_target  in   redirect byte address (bit 0 ignored)
//     inst_in        in   instruction at pc_out, same cycle
//     pc_out         out  current PC / imem address
//     ifid_inst      out  registered instruction
//     ifid_pc_next   out  registered PC+PC_STEP of that instruction
//     ifid_valid     out  IF/ID holds a real instruction
//     halted         out  fetch stopped on HALT
//     fetch_count    out  (FETCH_PERF_CNT_EN) valid IF/ID loads
//     stall_count    out  (FETCH_PERF_CNT_EN) stalled cycles
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int         ADDR_W   = DEF_ADDR_W,
  parameter int         INST_W   = DEF_INST_W,
  parameter int         PC_STEP  = DEF_PC_STEP,
  parameter logic [3:0] HALT_OPC = OPC_HALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [INST_W-1:0] inst_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0] ifid_inst,
  output logic [ADDR_W-1:0] ifid_pc_next,
  output logic              ifid_valid,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  logic [ADDR_W-1:0] pc;
  logic [0:0]        state;
  logic [ADDR_W-1:0] pc_plus;
  logic [ADDR_W-1:0] redirect_pc;
  logic              is_halt;
  logic              ifid_load;
  logic              ifid_flush;

  // Wraps modulo 2^ADDR_W by truncation.
  assign pc_plus     = pc + ADDR_W'(PC_STEP);
  // Odd targets are forced even by masking bit 0.
  assign redirect_pc = branch_target & ~{{(ADDR_W-1){1'b0}}, 1'b1};
  assign is_halt     = (inst_in[INST_W-1 -: 4] == HALT_OPC);

  assign ifid_load  = !branch_taken && !stall && (state == ST_RUN);
  // Redirects squash the wrong-path entry; HALTED inserts bubbles.
  assign ifid_flush = branch_taken || (!stall && (state == ST_HALTED));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      state <= ST_RUN;
    end else if (branch_taken) begin
      pc    <= redirect_pc;
      state <= ST_RUN;
    end else if (!stall && (state == ST_RUN)) begin
      // HALT enters IF/ID once and then the PC parks on it.
      if (is_halt) begin
        state <= ST_HALTED;
      end else begin
        pc <= pc_plus;
      end
    end
  end

  ifid_reg #(
    .W(INST_W + ADDR_W)
  ) u_ifid (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     ({inst_in, pc_plus}),
    .q     ({ifid_inst, ifid_pc_next}),
    .valid (ifid_valid)
  );

  assign pc_out = pc;
  assign halted = (state == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic count_stall;
  assign count_stall = stall && !branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= 16'h0000;
      stall_count <= 16'h0000;
    end else begin
      if (ifid_load && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (count_stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage with a combinational instruction
//   memory model. Each step drives inputs, waits one rising edge plus
//   1 ns, then compares outputs against hand-computed values.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [15:0] inst_in;
  logic [7:0]  pc_out;
  logic [15:0] ifid_inst;
  logic [7:0]  ifid_pc_next;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  logic [15:0] mem [0:255];
  int          testCount;
  int          failCount;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inst_in       (inst_in),
    .pc_out        (pc_out),
    .ifid_inst     (ifid_inst),
    .ifid_pc_next  (ifid_pc_next),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign inst_in = mem[pc_out];

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [7:0] pc,
                            input logic [15:0] inst, input logic [7:0] pn,
                            input logic valid, input logic hlt);
    checkOutput({tag, ".pc"},      32'(pc_out),       32'(pc));
    checkOutput({tag, ".inst"},    32'(ifid_inst),    32'(inst));
    checkOutput({tag, ".pc_next"}, 32'(ifid_pc_next), 32'(pn));
    checkOutput({tag, ".valid"},   32'(ifid_valid),   32'(valid));
    checkOutput({tag, ".halted"},  32'(halted),       32'(hlt));
  endtask

  task automatic applyStimulus(input logic s, input logic b,
                               input logic [7:0] tgt);
    stall         = s;
    branch_taken  = b;
    branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[8'h00] = 16'h0E20;
    mem[8'h02] = 16'h0B21;
    mem[8'h3E] = 16'hF000;

    rst           = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;

    #12;
    checkState("reset", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("reset.fetch_count", 32'(fetch_count), 32'h0);
    checkOutput("reset.stall_count", 32'(stall_count), 32'h0);
`endif
    rst = 1'b1;

    // Sequential fetch
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkState("seq0", 8'h02, 16'h0E20, 8'h02, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkState("seq1", 8'h04, 16'h0B21, 8'h04, 1'b1, 1'b0);

    // Three-cycle stall holds everything
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkState("stall", 8'h04, 16'h0B21, 8'h04, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkState("resume", 8'h06, 16'h1004, 8'h06, 1'b1, 1'b0);

    // Branch wins over simultaneous stall
    applyStimulus(1'b1, 1'b1, 8'h2A);
    checkState("br_stall", 8'h2A, 16'h1004, 8'h06, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkState("br_load", 8'h2C, 16'h102A, 8'h2C, 1'b1, 1'b0);

    // Odd target forced even
    applyStimulus(1'b0, 1'b1, 8'h2B);
    checkOutput("odd_tgt.pc", 32'(pc_out), 32'h2A);
    checkOutput("odd_tgt.valid", 32'(ifid_valid), 32'h0);

    // HALT at 3E
    applyStimulus(1'b0, 1'b1, 8'h3E);
    checkOutput("to_halt.pc", 32'(pc_out), 32'h3E);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkState("halt", 8'h3E, 16'hF000, 8'h40, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkState("halt_bub1", 8'h3E, 16'hF000, 8'h40, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkState("halt_bub2", 8'h3E, 16'hF000, 8'h40, 1'b0, 1'b1);

    // Redirect out of HALTED
    applyStimulus(1'b0, 1'b1, 8'h10);
    checkState("unhalt", 8'h10, 16'hF000, 8'h40, 1'b0, 1'b0);

    // PC wrap
    applyStimulus(1'b0, 1'b1, 8'hFE);
    checkOutput("wrap_br.pc", 32'(pc_out), 32'hFE);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkState("wrap", 8'h00, 16'h10FE, 8'h00, 1'b1, 1'b0);

`ifdef FETCH_PERF_CNT_EN
    // Loads: 0E20,0B21,1004,102A,F000,10FE; stalls: 3 (branch+stall excluded)
    checkOutput("perf.fetch_count", 32'(fetch_count), 32'd6);
    checkOutput("perf.stall_count", 32'(stall_count), 32'd3);
`endif

    // Asynchronous reset in the middle of a stall
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("pre_rst.pc", 32'(pc_out), 32'h00);
    #2;
    rst = 1'b0;
    #1;
    checkState("async_rst", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("async_rst.fetch_count", 32'(fetch_count), 32'h0);
    checkOutput("async_rst.stall_count", 32'(stall_count), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
